ht_cmd_arbiter: RTL and testbench
=================================

# ht_cmd_arbiter

Shares one hash-table command port between NUM_REQ independent requesters. Round-robin arbitration picks one `ht_command_t` per cycle, and a registered output stage presents it to the table. An in-order tag FIFO records the requester ID of every issued command. Each in-order `ht_result_t` from the table is steered back to the requester that issued it, and outstanding commands are bounded by MAX_OUTSTANDING.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- MAX_OUTSTANDING, 16: max commands in flight (output reg + table pipeline). Power of two, ≥2.
- ID_W, $clog2(NUM_REQ): derived requester-ID width; not overridable.
- CNT_W, $clog2(MAX_OUTSTANDING)+1: derived counter width.

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- req_cmd_i  in  NUM_REQ×ht_command_t  per-requester command
- req_valid_i  in  NUM_REQ  command valid; held with stable data until ready
- req_ready_o  out  NUM_REQ  one-hot-or-zero accept
- ht_cmd_o  out  ht_command_t  command to hash table
- ht_cmd_valid_o  out  1  command valid
- ht_cmd_ready_i  in  1  table accepts command
- ht_res_i  in  ht_result_t  result from table, in command order
- ht_res_valid_i  in  1  result valid; cannot be back-pressured
- res_o  out  ht_result_t  registered result, broadcast to all requesters
- res_valid_o  out  NUM_REQ  one-hot-or-zero: owner of res_o
- res_id_o  out  ID_W  requester ID of res_o
- outstanding_o  out  CNT_W  current in-flight count
- err_o  out  1  sticky: result arrived with tag FIFO empty

## Operation
- Load condition: `load = !ht_cmd_valid_o || ht_cmd_ready_i`. Also requires `outstanding_o < MAX_OUTSTANDING`, or a result popping in the same cycle.
- Arbitration:
  - Round-robin over `req_valid_i`, starting the search at `rr_ptr`.
  - The winner `w` gets `req_ready_o[w]=1` only when load holds.
  - All other `req_ready_o` bits are 0.
  - No combinational path from `req_valid_i` to other requesters' ready beyond the arbiter.
- On accept of `w`:
  - `ht_cmd_o <= req_cmd_i[w]`, `ht_cmd_valid_o <= 1`.
  - Push `w` into the tag FIFO.
  - `rr_ptr <= (w+1) mod NUM_REQ`.
- `rr_ptr` holds when nothing is accepted.
- Output stage: when `ht_cmd_ready_i=1` and nothing loads, `ht_cmd_valid_o <= 0`. `ht_cmd_o` never changes while valid and not ready.
- Outstanding counter:
  - +1 on accept, −1 on a result pop; net 0 when both occur in one cycle.
  - Never exceeds MAX_OUTSTANDING.
  - Tag FIFO depth is MAX_OUTSTANDING and never overflows.
- Result path, on `ht_res_valid_i`:
  - Pop the FIFO head `id`.
  - Next cycle: `res_o <= ht_res_i`, `res_id_o <= id`, `res_valid_o <= 1<<id`.
  - Otherwise `res_valid_o <= 0`.
- Unexpected result: on `ht_res_valid_i` with the FIFO empty (and no same-cycle push visible), set `err_o <= 1`. Then `res_valid_o` stays 0, nothing pops, and the counter holds.
- Push and pop in the same cycle on an empty FIFO: the push is not visible to the pop. Table latency is ≥1, so this is legal only as an error.

## Timing
- Request handshake to `ht_cmd_valid_o`: 1 cycle.
- `ht_res_valid_i` to `res_valid_o`: 1 cycle.
- Throughput: 1 command/cycle with `ht_cmd_ready_i=1` and fewer than MAX_OUTSTANDING in flight.
- Stall at full (`outstanding_o==MAX_OUTSTANDING`): all `req_ready_o=0` unless `ht_res_valid_i=1` that cycle.
- Reset values: `ht_cmd_valid_o=0`, `ht_cmd_o=0`, `req_ready_o=0`, `res_valid_o=0`, `res_o=0`, `res_id_o=0`, `outstanding_o=0`, `err_o=0`, `rr_ptr=0`, FIFO empty.
- Reset mid-operation: in-flight tags are discarded. Results arriving after reset for pre-reset commands set `err_o`. The table must be reset together with this block.
- `req_ready_o` is combinational from `req_valid_i`, `ht_cmd_ready_i`, `ht_res_valid_i` and registered state. All other outputs are registered.

## Structure
- `ht_command_t` and `ht_result_t` come from the shared hash-table package; this block adds no types there.
- ID_W and CNT_W are local derived localparams.
- Sub-module `ht_rr_arbiter`: NUM_REQ-wide round-robin grant with ptr input, one-hot grant and binary index outputs.
- The tag FIFO is inline: register array, wrap-around pointers with an extra bit for full/empty.

## Test plan
- **Single requester:** req 0 sends 3 SEARCH, keys 0x10/0x11/0x12, `ht_cmd_ready_i=1`, table delay 4 → ht_cmd keys on cycles 1,2,3 after the first valid; results return with `res_valid_o=4'b0001` in order.
- **All 4 requesters always valid:** grant order 0,1,2,3,0,…; over 40 cycles each gets exactly 10 grants.
- **Backpressure:** `ht_cmd_ready_i=0` for 5 cycles with req 2 valid → `ht_cmd_o` stable, `req_ready_o=0`, `rr_ptr` unchanged; ready=1 then issues the next.
- **Full boundary** (MAX_OUTSTANDING=16, results withheld): exactly 16 accepted, `outstanding_o=16`, `req_ready_o=0`. A result and a new request in the same cycle → one accepted, count stays 16.
- **Routing:** interleaved IDs 3,1,3,0 with INSERT ops → `res_valid_o` sequence 1000, 0010, 1000, 0001 with matching `res_id_o`.
- **Errors and reset:** `ht_res_valid_i` with the FIFO empty → `err_o=1` sticky, `res_valid_o=0`. `rst_i` high for 1 cycle mid-traffic → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ht_pkg.sv
// Shared hash-table command and result types used by every client of the table.
package ht_pkg;

  localparam int HT_KEY_W = 16;
  localparam int HT_VAL_W = 16;

  typedef enum logic [1:0] {
    HT_SEARCH = 2'd0,
    HT_INSERT = 2'd1,
    HT_DELETE = 2'd2,
    HT_NOP    = 2'd3
  } ht_op_e;

  typedef struct packed {
    ht_op_e              op;
    logic [HT_KEY_W-1:0] key;
    logic [HT_VAL_W-1:0] value;
  } ht_command_t;

  typedef struct packed {
    logic                found;
    logic [HT_KEY_W-1:0] key;
    logic [HT_VAL_W-1:0] value;
  } ht_result_t;

endpackage

// File: rtl/ht_rr_arbiter.sv
// Round-robin grant: the first asserted request at or after ptr_i (wrapping) wins.
module ht_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               grant_any_o
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0] slot;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    slot        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = {1'b0, ptr_i} + (ID_W+1)'(i);
      if (slot >= NUM_REQ_W) slot = slot - NUM_REQ_W;
      if (!grant_any_o && req_i[slot[ID_W-1:0]]) begin
        grant_any_o           = 1'b1;
        grant_o[slot[ID_W-1:0]] = 1'b1;
        grant_idx_o           = slot[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ht_cmd_arbiter.sv
// Shares one hash-table command port between NUM_REQ requesters and steers the
// in-order results back to their issuers through a tag FIFO.
module ht_cmd_arbiter
  import ht_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int ID_W            = $clog2(NUM_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  ht_command_t [NUM_REQ-1:0]  req_cmd_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output ht_command_t                ht_cmd_o,
  output logic                       ht_cmd_valid_o,
  input  logic                       ht_cmd_ready_i,
  input  ht_result_t                 ht_res_i,
  input  logic                       ht_res_valid_i,
  output ht_result_t                 res_o,
  output logic [NUM_REQ-1:0]         res_valid_o,
  output logic [ID_W-1:0]            res_id_o,
  output logic [CNT_W-1:0]           outstanding_o,
  output logic                       err_o
);

  localparam int              AW        = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_next;
  logic [ID_W:0]      rr_sum;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  logic [ID_W-1:0]    tag_mem [MAX_OUTSTANDING];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [ID_W-1:0]    head_id;
  logic [NUM_REQ-1:0] head_oh;
  logic               fifo_empty;

  logic               pop;
  logic               load;
  logic               accept;

  ht_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign head_id    = tag_mem[rd_ptr[AW-1:0]];

  // A pop needs a tag already in the FIFO; a same-cycle push is not visible to it.
  assign pop    = ht_res_valid_i && !fifo_empty;
  assign load   = !rst_i && (!ht_cmd_valid_o || ht_cmd_ready_i)
                  && ((outstanding_o < MAX_CNT) || pop);
  assign accept = load && grant_any;

  assign req_ready_o = load ? grant : '0;

  assign rr_sum  = {1'b0, grant_idx} + (ID_W+1)'(1);
  assign rr_next = (rr_sum >= NUM_REQ_W) ? '0 : rr_sum[ID_W-1:0];

  always_comb begin
    head_oh          = '0;
    head_oh[head_id] = 1'b1;
  end

  // Command output stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ht_cmd_valid_o <= 1'b0;
      ht_cmd_o       <= '0;
      rr_ptr         <= '0;
    end else if (accept) begin
      ht_cmd_valid_o <= 1'b1;
      ht_cmd_o       <= req_cmd_i[grant_idx];
      rr_ptr         <= rr_next;
    end else if (ht_cmd_ready_i) begin
      ht_cmd_valid_o <= 1'b0;
    end
  end

  // Tag FIFO and in-flight count
  always_ff @(posedge clk_i) begin
    if (accept) tag_mem[wr_ptr[AW-1:0]] <= grant_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding_o <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      outstanding_o <= outstanding_o + 1'b1;
      else if (!accept && pop) outstanding_o <= outstanding_o - 1'b1;
    end
  end

  // Result return stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_o <= '0;
      res_o       <= '0;
      res_id_o    <= '0;
      err_o       <= 1'b0;
    end else begin
      res_valid_o <= pop ? head_oh : '0;
      if (pop) begin
        res_o    <= ht_res_i;
        res_id_o <= head_id;
      end
      if (ht_res_valid_i && fifo_empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Bench for ht_cmd_arbiter: queue-based requesters and table, checked every cycle
// against a transaction-level model of the arbitration and routing rules.
module tb_ht_cmd_arbiter;
  import ht_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int MAXO    = 16;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(MAXO) + 1;

  logic                      clk;
  logic                      rst;
  ht_command_t [NUM_REQ-1:0] req_cmd;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  ht_command_t               ht_cmd;
  logic                      ht_cmd_valid;
  logic                      ht_cmd_ready;
  ht_result_t                res_in;
  logic                      res_in_valid;
  ht_result_t                res_out;
  logic [NUM_REQ-1:0]        res_valid;
  logic [ID_W-1:0]           res_id;
  logic [CNT_W-1:0]          outstanding;
  logic                      err;

  ht_cmd_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_cmd_i      (req_cmd),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .ht_cmd_o       (ht_cmd),
    .ht_cmd_valid_o (ht_cmd_valid),
    .ht_cmd_ready_i (ht_cmd_ready),
    .ht_res_i       (res_in),
    .ht_res_valid_i (res_in_valid),
    .res_o          (res_out),
    .res_valid_o    (res_valid),
    .res_id_o       (res_id),
    .outstanding_o  (outstanding),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  ht_command_t rq_q [NUM_REQ][$];
  ht_result_t  tbl_q[$];
  int          tbl_due[$];
  int          tags[$];
  int          grants [NUM_REQ];
  logic [NUM_REQ-1:0] obs_vld_log[$];
  int          obs_id_log[$];

  bit          m_cvalid;
  ht_command_t m_cmd;
  int          m_rr;
  logic [NUM_REQ-1:0] m_rv;
  logic [ID_W-1:0]    m_rid;
  ht_result_t  m_res;
  bit          m_err;

  bit rdy_en, res_en, force_res;
  int tdelay, cycle, last_due;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ht_result_t mk_res(input ht_command_t c);
    ht_result_t r;
    r.found = (c.op == HT_SEARCH);
    r.key   = c.key;
    r.value = c.value ^ 16'h5A5A;
    return r;
  endfunction

  function automatic ht_command_t rnd_cmd(input int r);
    ht_command_t c;
    c.op    = ht_op_e'(2'($urandom_range(0, 3)));
    c.key   = {4'(r), 12'($urandom)};
    c.value = 16'($urandom);
    return c;
  endfunction

  function automatic bit busy();
    bit b;
    b = m_cvalid || (tags.size() > 0) || (tbl_q.size() > 0) || (m_rv != '0);
    for (int r = 0; r < NUM_REQ; r++) if (rq_q[r].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic step(input bit chk_en);
    logic [NUM_REQ-1:0] exp_ready;
    int win, j, id, due;
    bit m_pop, m_load;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_valid[r] = (rq_q[r].size() > 0);
      req_cmd[r]   = req_valid[r] ? rq_q[r][0] : '0;
    end
    ht_cmd_ready = rdy_en;
    res_in_valid = 1'b0;
    res_in       = '0;
    if (force_res) begin
      res_in_valid = 1'b1;
      res_in.key   = 16'($urandom);
      res_in.value = 16'($urandom);
    end else if (res_en && tbl_q.size() > 0 && tbl_due[0] <= cycle) begin
      res_in_valid = 1'b1;
      res_in       = tbl_q.pop_front();
      void'(tbl_due.pop_front());
    end
    @(negedge clk);
    m_pop  = res_in_valid && (tags.size() > 0);
    m_load = !rst && (!m_cvalid || ht_cmd_ready) && ((tags.size() < MAXO) || m_pop);
    win = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (m_rr + k) % NUM_REQ;
      if (win < 0 && req_valid[j]) win = j;
    end
    exp_ready = (m_load && win >= 0) ? (NUM_REQ'(1) << win) : '0;
    if (chk_en) begin
      chk("req_ready",   64'(req_ready),    64'(exp_ready));
      chk("cmd_valid",   64'(ht_cmd_valid), 64'(m_cvalid));
      chk("cmd",         64'(ht_cmd),       64'(m_cmd));
      chk("res_valid",   64'(res_valid),    64'(m_rv));
      chk("res_id",      64'(res_id),       64'(m_rid));
      chk("res",         64'(res_out),      64'(m_res));
      chk("outstanding", 64'(outstanding),  64'(tags.size()));
      chk("err",         64'(err),          64'(m_err));
      if (res_valid != '0) begin
        obs_vld_log.push_back(res_valid);
        obs_id_log.push_back(int'(res_id));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_cvalid = 1'b0; m_cmd = '0; m_rr = 0; m_rv = '0; m_rid = '0; m_res = '0; m_err = 1'b0;
      tags.delete(); tbl_q.delete(); tbl_due.delete(); last_due = 0;
    end else begin
      if (m_cvalid && ht_cmd_ready) begin
        due = cycle + tdelay;
        if (due < last_due) due = last_due;
        tbl_q.push_back(mk_res(m_cmd));
        tbl_due.push_back(due);
        last_due = due;
      end
      m_rv = '0;
      if (res_in_valid) begin
        if (tags.size() > 0) begin
          id    = tags.pop_front();
          m_rv  = NUM_REQ'(1) << id;
          m_rid = ID_W'(id);
          m_res = res_in;
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_load && win >= 0) begin
        m_cmd    = rq_q[win].pop_front();
        m_cvalid = 1'b1;
        tags.push_back(win);
        m_rr = (win + 1) % NUM_REQ;
        grants[win]++;
      end else if (ht_cmd_ready) begin
        m_cvalid = 1'b0;
      end
    end
    cycle++;
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    rdy_en = 1'b1;
    res_en = 1'b1;
    n = 0;
    while (busy() && n < 500) begin
      step(1);
      n++;
    end
    chk({tag, "_drain_bound"}, 64'(n < 500), 64'd1);
  endtask

  initial begin
    ht_command_t c;
    logic [15:0] held_key;
    int ids [4];
    int n;
    rst = 1'b1; rdy_en = 1'b1; res_en = 1'b1; force_res = 1'b0;
    tdelay = 4; cycle = 0; last_due = 0;
    req_valid = '0; req_cmd = '0; ht_cmd_ready = 1'b0; res_in = '0; res_in_valid = 1'b0;
    step(0);
    step(1);
    chk("rst_cmd_valid", 64'(ht_cmd_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    // single requester, three searches
    obs_vld_log.delete();
    for (int k = 0; k < 3; k++) begin
      c.op = HT_SEARCH; c.key = 16'h0010 + 16'(k); c.value = 16'($urandom);
      rq_q[0].push_back(c);
    end
    drain("single");
    chk("single_res_count", 64'(obs_vld_log.size()), 64'd3);
    foreach (obs_vld_log[k]) chk("single_res_owner", 64'(obs_vld_log[k]), 64'b0001);

    // all requesters continuously valid
    for (int r = 0; r < NUM_REQ; r++) begin
      grants[r] = 0;
      for (int k = 0; k < 10; k++) rq_q[r].push_back(rnd_cmd(r));
    end
    for (int k = 0; k < 40; k++) step(1);
    for (int r = 0; r < NUM_REQ; r++) chk("fair_grants", 64'(grants[r]), 64'd10);
    drain("fair");

    // backpressure on the table side
    rq_q[2].push_back(rnd_cmd(2));
    rq_q[2].push_back(rnd_cmd(2));
    held_key = rq_q[2][0].key;
    rdy_en = 1'b0;
    for (int k = 0; k < 6; k++) step(1);
    chk("bp_hold_key", 64'(ht_cmd.key), 64'(held_key));
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    drain("bp");

    // full boundary with results withheld
    res_en = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) for (int k = 0; k < 5; k++) rq_q[r].push_back(rnd_cmd(r));
    for (int k = 0; k < 24; k++) step(1);
    chk("full_count", 64'(outstanding), 64'd16);
    chk("full_ready_low", 64'(req_ready), 64'd0);
    n = 0;
    for (int r = 0; r < NUM_REQ; r++) n += rq_q[r].size();
    res_en = 1'b1;
    step(1);
    chk("full_swap_count", 64'(outstanding), 64'd16);
    for (int r = 0; r < NUM_REQ; r++) n -= rq_q[r].size();
    chk("full_swap_accepts", 64'(n), 64'd1);
    drain("full");

    // routing of interleaved requesters
    obs_vld_log.delete(); obs_id_log.delete();
    ids = '{3, 1, 3, 0};
    tdelay = 3;
    foreach (ids[k]) begin
      c.op = HT_INSERT; c.key = 16'($urandom); c.value = 16'($urandom);
      rq_q[ids[k]].push_back(c);
      n = 0;
      while (rq_q[ids[k]].size() > 0 && n < 20) begin step(1); n++; end
    end
    drain("route");
    chk("route_count", 64'(obs_vld_log.size()), 64'd4);
    foreach (obs_vld_log[k]) begin
      if (k < 4) begin
        chk("route_owner", 64'(obs_vld_log[k]), 64'(NUM_REQ'(1) << ids[k]));
        chk("route_id", 64'(obs_id_log[k]), 64'(ids[k]));
      end
    end

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if ($urandom_range(0, 3) == 0 && rq_q[r].size() < 4) rq_q[r].push_back(rnd_cmd(r));
      rdy_en = ($urandom_range(0, 3) != 0);
      res_en = ($urandom_range(0, 4) != 0);
      tdelay = $urandom_range(1, 6);
      step(1);
    end
    drain("random");

    // unexpected result with nothing in flight
    force_res = 1'b1;
    step(1);
    force_res = 1'b0;
    step(1);
    step(1);
    chk("err_sticky", 64'(err), 64'd1);
    chk("err_no_route", 64'(res_valid), 64'd0);

    // reset in the middle of traffic
    tdelay = 2;
    for (int r = 0; r < NUM_REQ; r++) for (int k = 0; k < 3; k++) rq_q[r].push_back(rnd_cmd(r));
    for (int k = 0; k < 6; k++) step(1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_cmd_valid", 64'(ht_cmd_valid), 64'd0);
    chk("mid_rst_cmd", 64'(ht_cmd), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_res", 64'(res_out), 64'd0);
    chk("mid_rst_res_id", 64'(res_id), 64'd0);
    chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
